// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the two-port RAM arbiter.
package mem_arb_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_SPACE_DEF = 9;
  localparam int CNT_WIDTH_DEF  = 16;

  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA  = 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: requester handshakes, RAM drive and status of the arbiter.
// cnt0/cnt1 exist only when MEM_ARB_STATS_EN is defined.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_SPACE = ADDR_SPACE_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) ();

  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_SPACE-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  ack0, ack1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic [ADDR_SPACE-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_datain;
  logic                  ram_read, ram_write, ram_enable;
  logic [DATA_WIDTH-1:0] ram_dataout;
  logic                  busy;
`ifdef MEM_ARB_STATS_EN
  logic [CNT_WIDTH-1:0]  cnt0, cnt1;
`endif

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dataout,
    output ack0, ack1, rdata0, rdata1, ram_addr, ram_datain,
           ram_read, ram_write, ram_enable, busy
`ifdef MEM_ARB_STATS_EN
    , output cnt0, cnt1
`endif
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dataout,
    input  ack0, ack1, rdata0, rdata1, ram_addr, ram_datain,
           ram_read, ram_write, ram_enable, busy
`ifdef MEM_ARB_STATS_EN
    , input cnt0, cnt1
`endif
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2: two-way round-robin; after reset a tie goes to the data port.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  logic last_q, last_d;

  // One-hot grant; on a tie favour the port not served last.
  always_comb begin
    if (req_i == 2'b11) grant_o = last_q ? 2'b01 : 2'b10;
    else                grant_o = req_i;
  end

  // Remember which port won the most recent committed grant.
  always_comb begin
    last_d = last_q;
    if (update_i && (grant_o != 2'b00)) last_d = grant_o[PORT_DATA];
  end

  // Pointer register; reset marks the fetch port as last served.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= 1'b0;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sequences a single-port RAM for the fetch and data ports.
// Optional MEM_ARB_STATS_EN adds saturating per-port completion counters.
//
// state   | meaning
// IDLE    | nothing in flight; grant a pending request
// SETUP   | address, data and read/write registered toward RAM, enable low
// STROBE  | enable high; RAM performs the access on its rising edge
// CAPTURE | enable low; read data latched for the granted port
// DONE    | one-cycle ack; the other port may be granted directly
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_SPACE = ADDR_SPACE_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input logic      clock_i,
  input logic      clear_i,
  mem_arb_if.slave bus
);

  state_t state_q, state_d;
  logic [1:0] req_vec, req_eff, grant;
  logic       arb_update, grant_sel, grant_we;
  logic       gnt_q, gnt_d, we_q, we_d;
  logic [ADDR_SPACE-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_datain_q, ram_datain_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic ram_read_q, ram_read_d, ram_write_q, ram_write_d;
  logic ram_enable_q, ram_enable_d;
  logic ack0_q, ack0_d, ack1_q, ack1_d;

  assign req_vec = {bus.req1, bus.req0};

  // The port acked in DONE still holds req; mask it so only the other port can chain in.
  always_comb begin
    req_eff = req_vec;
    if (state_q == DONE) req_eff[gnt_q] = 1'b0;
  end

  assign arb_update = ((state_q == IDLE) || (state_q == DONE)) && (grant != 2'b00);
  assign grant_sel  = grant[PORT_DATA];
  assign grant_we   = grant_sel ? bus.we1 : bus.we0;

  rr_arbiter2 u_rr (
    .clk_i    (clock_i),
    .rst_i    (clear_i),
    .req_i    (req_eff),
    .update_i (arb_update),
    .grant_o  (grant)
  );

  // State register.
  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_update) state_d = SETUP;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE:    state_d = arb_update ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered RAM drive, ack and read-data outputs.
  always_comb begin
    gnt_d        = gnt_q;
    we_d         = we_q;
    ram_addr_d   = ram_addr_q;
    ram_datain_d = ram_datain_q;
    ram_read_d   = ram_read_q;
    ram_write_d  = ram_write_q;
    ram_enable_d = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      SETUP: ram_enable_d = 1'b1;
      CAPTURE: begin
        ram_read_d  = 1'b0;
        ram_write_d = 1'b0;
        if (gnt_q) ack1_d = 1'b1;
        else       ack0_d = 1'b1;
        if (!we_q) begin
          if (gnt_q) rdata1_d = bus.ram_dataout;
          else       rdata0_d = bus.ram_dataout;
        end
      end
      default: ;
    endcase
    if (arb_update) begin
      gnt_d        = grant_sel;
      we_d         = grant_we;
      ram_addr_d   = grant_sel ? bus.addr1 : bus.addr0;
      ram_datain_d = grant_sel ? bus.wdata1 : bus.wdata0;
      ram_read_d   = ~grant_we;
      ram_write_d  = grant_we;
    end
  end

  // Output and latched-request registers; clear drops everything to zero at once.
  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      ram_addr_q   <= '0;
      ram_datain_q <= '0;
      ram_read_q   <= 1'b0;
      ram_write_q  <= 1'b0;
      ram_enable_q <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      ram_addr_q   <= ram_addr_d;
      ram_datain_q <= ram_datain_d;
      ram_read_q   <= ram_read_d;
      ram_write_q  <= ram_write_d;
      ram_enable_q <= ram_enable_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_datain = ram_datain_q;
  assign bus.ram_read   = ram_read_q;
  assign bus.ram_write  = ram_write_q;
  assign bus.ram_enable = ram_enable_q;
  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.rdata0     = rdata0_q;
  assign bus.rdata1     = rdata1_q;
  assign bus.busy       = (state_q != IDLE);

`ifdef MEM_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt1_q;

  // Count completions of the granted port in DONE, saturating at all-ones.
  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (state_q == DONE) begin
      if (gnt_q) begin
        if (cnt1_q != '1) cnt1_q <= cnt1_q + 1'b1;
      end else begin
        if (cnt0_q != '1) cnt0_q <= cnt0_q + 1'b1;
      end
    end
  end

  assign bus.cnt0 = cnt0_q;
  assign bus.cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural RAM.
module tb_mem_arbiter;

`ifdef MEM_ARB_STATS_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  int   en_edges = 0;
  logic [8:0]  last_en_addr = '0;
  logic        both_seen = 1'b0;
  logic [31:0] mem [0:511];

  mem_arb_if #(.DATA_WIDTH(32), .ADDR_SPACE(9), .CNT_WIDTH(CW)) bus ();

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_SPACE(9), .CNT_WIDTH(CW)) dut (
    .clock_i (clock),
    .clear_i (clear),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  // Behavioural RAM: acts on the rising edge of ram_enable.
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[9'h010] = 32'h1111_0010;
    mem[9'h020] = 32'h2222_0020;
    mem[9'h1FF] = 32'hA5A5_1FF0;
    bus.ram_dataout = '0;
    forever begin
      @(posedge bus.ram_enable);
      en_edges++;
      last_en_addr = bus.ram_addr;
      if (bus.ram_write) mem[bus.ram_addr] = bus.ram_datain;
      if (bus.ram_read)  bus.ram_dataout = mem[bus.ram_addr];
    end
  end

  always @(negedge clock) if (bus.ram_read && bus.ram_write) both_seen = 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int p, input logic we, input logic [8:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) bus.req0 = 1'b0;
    else        bus.req1 = 1'b0;
  endtask

  task automatic access(input int p, input logic we, input logic [8:0] a,
                        input logic [31:0] d, input string tag);
    int lat;
    lat = 99;
    drive(p, we, a, d);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (((p == 0) ? bus.ack0 : bus.ack1) === 1'b1) begin
        lat = c;
        break;
      end
    end
    drop(p);
    tick();
    check({tag, "_lat"}, 64'(lat), 64'd4);
  endtask

  task automatic tie(input string tag, input int exp0, input int exp1);
    int a0, a1;
    a0 = 99;
    a1 = 99;
    drive(0, 1'b0, 9'h010, 32'h0);
    drive(1, 1'b0, 9'h020, 32'h0);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.ack0 === 1'b1 && a0 == 99) begin a0 = c; drop(0); end
      if (bus.ack1 === 1'b1 && a1 == 99) begin a1 = c; drop(1); end
      if (a0 != 99 && a1 != 99) break;
    end
    drop(0);
    drop(1);
    tick();
    check({tag, "_ack0_cycle"}, 64'(a0), 64'(exp0));
    check({tag, "_ack1_cycle"}, 64'(a1), 64'(exp1));
    check({tag, "_rdata0"}, 64'(bus.rdata0), 64'h1111_0010);
    check({tag, "_rdata1"}, 64'(bus.rdata1), 64'h2222_0020);
  endtask

  initial begin
    int lat;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

    tick();
    check("reset_ctrl", 64'({bus.ack0, bus.ack1, bus.ram_enable, bus.ram_read,
                             bus.ram_write, bus.busy}), 64'h0);
    check("reset_bus", 64'({bus.ram_addr, bus.ram_datain, bus.rdata0, bus.rdata1}), 64'h0);
    clear = 1'b0;
    tick();

    // Write port 1 with per-phase protocol checks.
    drive(1, 1'b1, 9'h005, 32'hDEAD_BEEF);
    tick();
    check("setup_ctrl", 64'({bus.busy, bus.ram_enable, bus.ram_read, bus.ram_write}), 64'b1001);
    check("setup_addr", 64'(bus.ram_addr), 64'h005);
    check("setup_data", 64'(bus.ram_datain), 64'hDEAD_BEEF);
    tick();
    check("strobe_ctrl", 64'({bus.ram_enable, bus.ram_read, bus.ram_write}), 64'b101);
    tick();
    check("capture_ctrl", 64'({bus.ram_enable, bus.ram_read, bus.ram_write, bus.ack1}), 64'b0010);
    tick();
    check("done_ctrl", 64'({bus.ack1, bus.ack0, bus.ram_read, bus.ram_write, bus.busy}), 64'b10001);
    drop(1);
    tick();
    check("idle_after", 64'({bus.ack1, bus.busy}), 64'b00);
    check("mem_005", 64'(mem[9'h005]), 64'hDEAD_BEEF);

    access(1, 1'b0, 9'h005, 32'h0, "rd005");
    check("rd005_data", 64'(bus.rdata1), 64'hDEAD_BEEF);
    check("en_edges_2", 64'(en_edges), 64'd2);

    // Fresh reset so the next tie is the first one.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_rdata1", 64'(bus.rdata1), 64'h0);
    tick();

    tie("tie1", 8, 4);
    access(1, 1'b1, 9'h030, 32'hCAFE_0030, "solo1");
    tie("tie2", 4, 8);

    // Inputs changed after grant must not disturb the access.
    lat = 99;
    drive(1, 1'b0, 9'h005, 32'h0);
    tick();
    bus.addr1 = 9'h1FF; bus.we1 = 1'b1; bus.wdata1 = 32'h0;
    for (int c = 2; c <= 20; c++) begin
      tick();
      if (bus.ack1 === 1'b1) begin lat = c; break; end
    end
    drop(1);
    tick();
    check("chg_lat", 64'(lat), 64'd4);
    check("chg_ram_addr", 64'(last_en_addr), 64'h005);
    check("chg_rdata1", 64'(bus.rdata1), 64'hDEAD_BEEF);
    check("chg_mem1ff", 64'(mem[9'h1FF]), 64'hA5A5_1FF0);

    access(1, 1'b0, 9'h1FF, 32'h0, "bound");
    check("bound_data", 64'(bus.rdata1), 64'hA5A5_1FF0);
    check("en_edges_9", 64'(en_edges), 64'd9);
    check("never_both", 64'(both_seen), 64'd0);

    // Clear during SETUP: the write must never be strobed.
    drive(0, 1'b1, 9'h041, 32'h0000_0BAD);
    tick();
    clear = 1'b1;
    #1;
    check("clr_setup_outs", 64'({bus.busy, bus.ram_write, bus.ram_enable}), 64'b000);
    drop(0);
    tick();
    clear = 1'b0;
    check("clr_setup_edges", 64'(en_edges), 64'd9);
    check("clr_setup_mem", 64'(mem[9'h041]), 64'h0);

    // Clear during STROBE: outputs drop at once, no ack, write already landed.
    drive(0, 1'b1, 9'h040, 32'h1234_5678);
    tick();
    tick();
    check("strobe_en", 64'(bus.ram_enable), 64'd1);
    clear = 1'b1;
    #1;
    check("clr_strobe_ctrl", 64'({bus.ram_enable, bus.ram_read, bus.ram_write, bus.busy,
                                  bus.ack0, bus.ack1}), 64'h0);
    check("clr_strobe_bus", 64'({bus.ram_addr, bus.ram_datain}), 64'h0);
    drop(0);
    tick();
    check("clr_no_ack", 64'({bus.ack0, bus.ack1}), 64'h0);
    clear = 1'b0;
    access(0, 1'b0, 9'h040, 32'h0, "after_clr");
    check("after_clr_data", 64'(bus.rdata0), 64'h1234_5678);
    check("en_edges_11", 64'(en_edges), 64'd11);

`ifdef MEM_ARB_STATS_EN
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("cnt_reset", 64'({bus.cnt0, bus.cnt1}), 64'h0);
    tick();
    for (int i = 0; i < 20; i++) access(0, 1'b0, 9'(i), 32'h0, "stats");
    check("cnt0_sat", 64'(bus.cnt0), 64'd15);
    check("cnt1_zero", 64'(bus.cnt1), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
